// File: rtl/stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_ctrl
// Purpose  : Button front end and control FSM for the stopwatch datapath.
//            Two raw push buttons are synchronized, debounced on a slow
//            sample tick and converted to single-cycle press pulses. The
//            pulses drive a 4-state FSM (IDLE/RUN/LAP/PAUSE) that produces
//            the counter run-enable, a counter clear pulse and the display
//            lap-freeze request.
// Ports    : clk          - system clock, rising edge
//            rst_p        - asynchronous active-high reset
//            btn_start    - raw start/stop button (bouncy, asynchronous)
//            btn_lap      - raw lap/clear button (bouncy, asynchronous)
//            start_pedge  - 1-clk pulse on debounced start press
//            lap_pedge    - 1-clk pulse on debounced lap press
//            run_en       - counter enable (RUN, LAP)
//            clr_p        - 1-clk counter/display clear pulse
//            lap_hold     - display freeze request (LAP only)
//            state        - FSM state: IDLE=0, RUN=1, LAP=2, PAUSE=3
// Revision : 1.0 - initial fully synchronous release
// ============================================================================
module stopwatch_ctrl #(
    parameter int TICK_DIV     = 100000,
    parameter int STABLE_TICKS = 10
) (
    input  logic       clk,
    input  logic       rst_p,
    input  logic       btn_start,
    input  logic       btn_lap,
    output logic       start_pedge,
    output logic       lap_pedge,
    output logic       run_en,
    output logic       clr_p,
    output logic       lap_hold,
    output logic [1:0] state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW = $clog2(STABLE_TICKS + 1);

    localparam logic [TW-1:0] C_TICK_LAST   = TW'(TICK_DIV - 1);
    // Acceptance happens when the counter would step onto STABLE_TICKS.
    localparam logic [SW-1:0] C_STABLE_LAST = SW'(STABLE_TICKS - 1);

    // ------------------------------------------------------------------
    // Debounce sample tick
    // ------------------------------------------------------------------
    logic [TW-1:0] tick_cnt_q;
    logic [TW-1:0] tick_cnt_d;
    logic          w_tick;

    assign w_tick     = (tick_cnt_q == C_TICK_LAST);
    assign tick_cnt_d = w_tick ? '0 : tick_cnt_q + 1'b1;

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    // ------------------------------------------------------------------
    // Per-button synchronizer, debouncer and rising-edge pulse
    // bit 0 = start/stop, bit 1 = lap/clear
    // ------------------------------------------------------------------
    logic [1:0] w_btn_raw;
    logic [1:0] w_pedge;

    assign w_btn_raw = {btn_lap, btn_start};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic          sync1_q;
        logic          sync2_q;
        logic          level_q;
        logic          level_d;
        logic          level_prev_q;
        logic          pedge_q;
        logic [SW-1:0] stable_q;
        logic [SW-1:0] stable_d;

        // A sample equal to the current level clears the run, so any
        // bounce back before acceptance restarts the count from zero.
        always_comb begin
            level_d  = level_q;
            stable_d = stable_q;
            if (w_tick) begin
                if (sync2_q != level_q) begin
                    if (stable_q == C_STABLE_LAST) begin
                        level_d  = sync2_q;
                        stable_d = '0;
                    end else begin
                        stable_d = stable_q + 1'b1;
                    end
                end else begin
                    stable_d = '0;
                end
            end
        end

        always_ff @(posedge clk or posedge rst_p) begin
            if (rst_p) begin
                sync1_q      <= 1'b0;
                sync2_q      <= 1'b0;
                level_q      <= 1'b0;
                level_prev_q <= 1'b0;
                pedge_q      <= 1'b0;
                stable_q     <= '0;
            end else begin
                sync1_q      <= w_btn_raw[gi];
                sync2_q      <= sync1_q;
                level_q      <= level_d;
                level_prev_q <= level_q;
                pedge_q      <= level_q & ~level_prev_q;
                stable_q     <= stable_d;
            end
        end

        assign w_pedge[gi] = pedge_q;
    end

    assign start_pedge = w_pedge[0];
    assign lap_pedge   = w_pedge[1];

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_LAP   = 2'd2,
        S_PAUSE = 2'd3
    } state_t;

    state_t state_q;
    state_t state_d;
    logic   clr_q;
    logic   clr_d;

    // Start is tested first so a simultaneous lap press is dropped.
    always_comb begin
        state_d = state_q;
        clr_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start_pedge) begin
                    state_d = S_RUN;
                end else if (lap_pedge) begin
                    clr_d   = 1'b1;
                end
            end
            S_RUN: begin
                if (start_pedge) begin
                    state_d = S_PAUSE;
                end else if (lap_pedge) begin
                    state_d = S_LAP;
                end
            end
            S_LAP: begin
                if (start_pedge) begin
                    state_d = S_PAUSE;
                end else if (lap_pedge) begin
                    state_d = S_RUN;
                end
            end
            S_PAUSE: begin
                if (start_pedge) begin
                    state_d = S_RUN;
                end else if (lap_pedge) begin
                    state_d = S_IDLE;
                    clr_d   = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst_p) begin
        if (rst_p) begin
            state_q <= S_IDLE;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            clr_q   <= clr_d;
        end
    end

    // Decoded straight from the state register: no extra cycle, no glitch.
    assign run_en   = (state_q == S_RUN) || (state_q == S_LAP);
    assign lap_hold = (state_q == S_LAP);
    assign clr_p    = clr_q;
    assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_stopwatch_ctrl
// Purpose  : Self-checking bench for stopwatch_ctrl (TICK_DIV=4,
//            STABLE_TICKS=3). Expected press events are queued at stimulus
//            time; a negedge monitor pops and compares them.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stopwatch_ctrl;

    localparam int TD      = 4;
    localparam int ST      = 3;
    localparam int LAT_MIN = (ST - 1) * TD + 3;
    localparam int LAT_MAX = ST * TD + 3;
    localparam int HOLD    = 20;

    logic       clk = 1'b0;
    logic       rst_p;
    logic       btn_start;
    logic       btn_lap;
    logic       start_pedge;
    logic       lap_pedge;
    logic       run_en;
    logic       clr_p;
    logic       lap_hold;
    logic [1:0] state;

    stopwatch_ctrl #(
        .TICK_DIV     (TD),
        .STABLE_TICKS (ST)
    ) dut (
        .clk         (clk),
        .rst_p       (rst_p),
        .btn_start   (btn_start),
        .btn_lap     (btn_lap),
        .start_pedge (start_pedge),
        .lap_pedge   (lap_pedge),
        .run_en      (run_en),
        .clr_p       (clr_p),
        .lap_hold    (lap_hold),
        .state       (state)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit sp;
        bit lp;
        int nstate;
        bit clr;
        int press_cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: transition tables (IDLE, RUN, LAP, PAUSE)
    int model_state = 0;
    int nxt_start [4] = '{1, 3, 3, 1};
    int nxt_lap   [4] = '{0, 2, 1, 0};
    bit clr_lap   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    function automatic exp_t predict(input bit s, input bit l, input int pc);
        exp_t e;
        e.sp        = s;
        e.lp        = l;
        e.press_cyc = pc;
        if (s) begin
            e.nstate = nxt_start[model_state];
            e.clr    = 1'b0;
        end else begin
            e.nstate = nxt_lap[model_state];
            e.clr    = clr_lap[model_state];
        end
        model_state = e.nstate;
        return e;
    endfunction

    function automatic void chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    function automatic void flag(input string name, input int act);
        tests++;
        fails++;
        $display("FAIL %s: unexpected value %0d (cycle %0d)", name, act, cyc);
    endfunction

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    bit   post = 1'b0;
    exp_t cur;
    int   prev_state = 0;

    always @(negedge clk) begin
        if (rst_p) begin
            post       = 1'b0;
            prev_state = 0;
        end else begin
            if (post) begin
                chk("state_after_press", int'(state), cur.nstate);
                chk("clr_p", int'(clr_p), int'(cur.clr));
                chk("run_en", int'(run_en), int'(cur.nstate == 1 || cur.nstate == 2));
                chk("lap_hold", int'(lap_hold), int'(cur.nstate == 2));
                post = 1'b0;
            end else begin
                if (clr_p) flag("spurious_clr_p", int'(clr_p));
                if (int'(state) != prev_state) flag("spurious_state_change", int'(state));
            end
            if (start_pedge || lap_pedge) begin
                if (sb.size() == 0) begin
                    flag("spurious_pedge", {start_pedge, lap_pedge});
                end else begin
                    cur = sb.pop_front();
                    chk("start_pedge", int'(start_pedge), int'(cur.sp));
                    chk("lap_pedge", int'(lap_pedge), int'(cur.lp));
                    tests++;
                    if ((cyc - cur.press_cyc) < LAT_MIN || (cyc - cur.press_cyc) > LAT_MAX) begin
                        fails++;
                        $display("FAIL pedge_latency: got %0d expected %0d..%0d",
                                 cyc - cur.press_cyc, LAT_MIN, LAT_MAX);
                    end
                    post = 1'b1;
                end
            end
            prev_state = int'(state);
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic press(input bit s, input bit l);
        @(negedge clk);
        sb.push_back(predict(s, l, cyc));
        btn_start = s;
        btn_lap   = l;
        repeat (HOLD) @(negedge clk);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        repeat (HOLD) @(negedge clk);
    endtask

    task automatic drive(input bit on_lap, input bit v);
        if (on_lap) btn_lap = v;
        else        btn_start = v;
    endtask

    // High bursts of at most 6 clks see at most 2 samples; low gaps of at
    // least 4 clks see at least one sample, so no burst can be accepted.
    task automatic bounce(input bit on_lap, input int segs, input int hi_max);
        for (int i = 0; i < segs; i++) begin
            drive(on_lap, 1'b1);
            repeat ($urandom_range(1, hi_max)) @(negedge clk);
            drive(on_lap, 1'b0);
            repeat ($urandom_range(4, 8)) @(negedge clk);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_state"}, int'(state), 0);
        chk({tag, "_run_en"}, int'(run_en), 0);
        chk({tag, "_lap_hold"}, int'(lap_hold), 0);
        chk({tag, "_clr_p"}, int'(clr_p), 0);
        chk({tag, "_pedges"}, int'({start_pedge, lap_pedge}), 0);
    endtask

    initial begin
        rst_p     = 1'b1;
        btn_start = 1'b1;
        btn_lap   = 1'b1;

        // Reset with both buttons held; start wins after release.
        repeat (5) @(negedge clk);
        check_idle_outputs("reset");
        model_state = 0;
        sb.push_back(predict(1'b1, 1'b1, cyc));
        rst_p = 1'b0;
        #1;
        check_idle_outputs("post_reset");
        repeat (HOLD - 1) @(negedge clk);
        btn_start = 1'b0;
        btn_lap   = 1'b0;
        repeat (HOLD) @(negedge clk);

        // Back to IDLE, then start, lap, lap, start, lap
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);
        press(1'b0, 1'b1);
        press(1'b1, 1'b0);
        press(1'b0, 1'b1);

        // Simultaneous press from RUN
        press(1'b1, 1'b0);
        press(1'b1, 1'b1);

        // Regular bounce every 5 clks, then a clean hold
        for (int i = 0; i < 6; i++) begin
            btn_start = 1'b1;
            repeat (5) @(negedge clk);
            btn_start = 1'b0;
            repeat (5) @(negedge clk);
        end
        press(1'b1, 1'b0);

        // Randomized operations
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 4))
                0: press(1'b1, 1'b0);
                1: press(1'b0, 1'b1);
                2: press(1'b1, 1'b1);
                3: bounce(1'($urandom_range(0, 1)), int'($urandom_range(2, 6)), 6);
                default: begin
                    bounce(1'b0, int'($urandom_range(1, 4)), 6);
                    press(1'b1, 1'b0);
                end
            endcase
        end

        // Reset while a lap press is mid-debounce in RUN
        while (model_state != 1) begin
            if (model_state == 2) press(1'b0, 1'b1);
            else                  press(1'b1, 1'b0);
        end
        @(negedge clk);
        btn_lap = 1'b1;
        repeat (10) @(posedge clk);
        #2;
        rst_p = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        repeat (3) @(negedge clk);
        model_state = 0;
        sb.push_back(predict(1'b0, 1'b1, cyc));
        rst_p = 1'b0;
        repeat (HOLD) @(negedge clk);
        btn_lap = 1'b0;
        repeat (HOLD) @(negedge clk);

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", sb.size(), 0);
        chk("no_pending_check", int'(post), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
